// File: rtl/light_sequencer.sv
// Traffic-light phase controller: cycle counter, per-cycle latches, phase FSM.
// Optional LIGHT_SEQ_WATCHDOG_EN: a non-MG state at counter wrap traps in FLT.
module light_sequencer #(
  parameter logic [5:0] CYCLE_MAX = 6'd47,
  parameter int         TW        = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          pedButton,
  input  logic [TW-1:0] mainSensor,
  input  logic [TW-1:0] sideSensor,
  input  logic          enable,
  output logic [5:0]    counter,
  output logic          PED,
  output logic [TW-1:0] mainTrafficIn,
  output logic [TW-1:0] sideTrafficIn,
  output logic [2:0]    mainLight,
  output logic [2:0]    sideLight,
  output logic          walk,
  output logic          fault
);

  typedef enum logic [2:0] {
    MG, MY, AR1, SG, SY, AR2, PW, FLT
  } state_e;

  state_e        state_q, state_d;
  logic [5:0]    counter_q, counter_d;
  logic          ped_q, pending_q;
  logic [TW-1:0] main_tr_q, side_tr_q;
  logic [2:0]    main_q, side_q;
  logic          walk_q;
  logic          wrap, adv;

  assign wrap      = tick && (counter_q == CYCLE_MAX);
  assign adv       = enable && tick;
  assign counter_d = wrap ? 6'd0 : counter_q + 6'd1;

  function automatic state_e next_f(state_e s, logic p);
    unique case (s)
      MG:      next_f = MY;
      MY:      next_f = AR1;
      AR1:     next_f = SG;
      SG:      next_f = SY;
      SY:      next_f = AR2;
      AR2:     next_f = p ? PW : MG;
      PW:      next_f = MG;
      default: next_f = FLT;
    endcase
  endfunction

  // {main, side, walk} lamp pattern shown while in a state
  function automatic logic [6:0] lamp_f(state_e s);
    unique case (s)
      MG:      lamp_f = {3'b001, 3'b100, 1'b0};
      MY:      lamp_f = {3'b010, 3'b100, 1'b0};
      SG:      lamp_f = {3'b100, 3'b001, 1'b0};
      SY:      lamp_f = {3'b100, 3'b010, 1'b0};
      PW:      lamp_f = {3'b100, 3'b100, 1'b1};
      default: lamp_f = {3'b100, 3'b100, 1'b0};
    endcase
  endfunction

  assign state_d = next_f(state_q, ped_q);

  // Free-running cycle position, advancing on each tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       counter_q <= 6'd0;
    else if (tick) counter_q <= counter_d;
  end

  // Per-cycle snapshot of sensors and pedestrian request at wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ped_q     <= 1'b0;
      pending_q <= 1'b0;
      main_tr_q <= '0;
      side_tr_q <= '0;
    end else if (wrap) begin
      ped_q     <= pending_q | pedButton;
      pending_q <= 1'b0;
      main_tr_q <= mainSensor;
      side_tr_q <= sideSensor;
    end else if (pedButton) begin
      pending_q <= 1'b1;
    end
  end

`ifdef LIGHT_SEQ_WATCHDOG_EN
  logic fault_q;

  // Phase FSM with registered lamps; FLT traps until reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MG;
      main_q  <= 3'b001;
      side_q  <= 3'b100;
      walk_q  <= 1'b0;
      fault_q <= 1'b0;
    end else if (wrap && state_q != MG) begin
      state_q <= FLT;
      main_q  <= 3'b100;
      side_q  <= 3'b100;
      walk_q  <= 1'b0;
      fault_q <= 1'b1;
    end else if (adv && state_q != FLT) begin
      state_q                  <= state_d;
      {main_q, side_q, walk_q} <= lamp_f(state_d);
    end
  end

  assign fault = fault_q;
`else
  // Phase FSM with registered lamps; state carries across wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MG;
      main_q  <= 3'b001;
      side_q  <= 3'b100;
      walk_q  <= 1'b0;
    end else if (adv) begin
      state_q                  <= state_d;
      {main_q, side_q, walk_q} <= lamp_f(state_d);
    end
  end

  assign fault = 1'b0;
`endif

  assign counter       = counter_q;
  assign PED           = ped_q;
  assign mainTrafficIn = main_tr_q;
  assign sideTrafficIn = side_tr_q;
  assign mainLight     = main_q;
  assign sideLight     = side_q;
  assign walk          = walk_q;

endmodule

// File: tb/tb_light_sequencer.sv
// Directed bench for light_sequencer; enable comes from a behavioural
// model of the enable generator, or a forced "only at 11" pattern.
module tb_light_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       pedButton;
  logic [2:0] mainSensor, sideSensor;
  logic       enable;
  logic [5:0] counter;
  logic       PED;
  logic [2:0] mainTrafficIn, sideTrafficIn;
  logic [2:0] mainLight, sideLight;
  logic       walk, fault;

  int         nvec = 0;
  int         nerr = 0;
  logic       tdiv = 1'b0;
  logic [1:0] ph   = 2'd0;
  int         en_mode = 1;

  always #5 clk = ~clk;

  light_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .pedButton    (pedButton),
    .mainSensor   (mainSensor),
    .sideSensor   (sideSensor),
    .enable       (enable),
    .counter      (counter),
    .PED          (PED),
    .mainTrafficIn(mainTrafficIn),
    .sideTrafficIn(sideTrafficIn),
    .mainLight    (mainLight),
    .sideLight    (sideLight),
    .walk         (walk),
    .fault        (fault)
  );

  always @(negedge clk) ph = ph + 2'd1;
  assign tick = tdiv ? (ph == 2'd0) : 1'b1;

  function automatic logic en_f(logic [5:0] c, logic p,
                                logic [2:0] m, logic [2:0] s);
    logic [5:0] t0;
    t0 = (m > s) ? 6'd15 : 6'd11;
    return (c == t0) || (c == t0 + 6'd2) || (c == t0 + 6'd4) ||
           (c == 6'd25) || (c == 6'd27) || (c == 6'd29) ||
           (p && c == 6'd39);
  endfunction

  assign enable = (en_mode == 1) ?
                    en_f(counter, PED, mainTrafficIn, sideTrafficIn) :
                  (en_mode == 2) ? (counter == 6'd11) : 1'b0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Step at least one falling edge, stop when counter reaches c
  task automatic at(input logic [5:0] c);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (counter != c && n < 300);
    if (counter != c) begin
      nerr++;
      $display("FAIL timeout: counter %0d never reached %0d", counter, c);
    end
  endtask

  task automatic lamps(input string tag, input logic [2:0] m,
                       input logic [2:0] s, input logic w);
    chk({tag, ".main"}, 32'(mainLight), 32'(m));
    chk({tag, ".side"}, 32'(sideLight), 32'(s));
    chk({tag, ".walk"}, 32'(walk), 32'(w));
  endtask

  initial begin
    rst        = 1'b1;
    pedButton  = 1'b0;
    mainSensor = 3'd5;
    sideSensor = 3'd2;
    @(negedge clk);
    @(negedge clk);
    chk("rst.counter", 32'(counter), 32'd0);
    lamps("rst", 3'b001, 3'b100, 1'b0);
    chk("rst.PED", 32'(PED), 32'd0);
    chk("rst.mti", 32'(mainTrafficIn), 32'd0);
    chk("rst.sti", 32'(sideTrafficIn), 32'd0);
    chk("rst.fault", 32'(fault), 32'd0);
    rst = 1'b0;

    // cycle 1: latched 0/0, advances at 11,13,15,25,27,29
    at(6'd11); lamps("c1.11", 3'b001, 3'b100, 1'b0);
    at(6'd12); lamps("c1.MY", 3'b010, 3'b100, 1'b0);
    at(6'd14); lamps("c1.AR1", 3'b100, 3'b100, 1'b0);
    at(6'd16); lamps("c1.SG", 3'b100, 3'b001, 1'b0);
    at(6'd26); lamps("c1.SY", 3'b100, 3'b010, 1'b0);
    at(6'd28); lamps("c1.AR2", 3'b100, 3'b100, 1'b0);
    at(6'd30); lamps("c1.MG", 3'b001, 3'b100, 1'b0);
    chk("c1.mti", 32'(mainTrafficIn), 32'd0);

    // cycle 2: latched 5/2, main green held until 15
    at(6'd0);
    chk("c2.mti", 32'(mainTrafficIn), 32'd5);
    chk("c2.sti", 32'(sideTrafficIn), 32'd2);
    chk("c2.PED", 32'(PED), 32'd0);
    at(6'd12); lamps("c2.12", 3'b001, 3'b100, 1'b0);
    at(6'd16); lamps("c2.MY", 3'b010, 3'b100, 1'b0);
    at(6'd20); lamps("c2.SG", 3'b100, 3'b001, 1'b0);
    at(6'd30); lamps("c2.MG", 3'b001, 3'b100, 1'b0);

    // press at counter 5: PED only from the next cycle
    at(6'd5);
    pedButton = 1'b1;
    @(negedge clk);
    pedButton = 1'b0;
    chk("p.PED6", 32'(PED), 32'd0);
    at(6'd47); chk("p.PED47", 32'(PED), 32'd0);
    at(6'd0);  chk("p.PED0", 32'(PED), 32'd1);
    at(6'd30); lamps("p.PW", 3'b100, 3'b100, 1'b1);
    at(6'd39); lamps("p.PW39", 3'b100, 3'b100, 1'b1);
    at(6'd40); lamps("p.MG", 3'b001, 3'b100, 1'b0);
    at(6'd0);  chk("p.PEDnext", 32'(PED), 32'd0);

    // press on the wrap clock goes straight to PED, pending stays clear
    at(6'd47);
    pedButton = 1'b1;
    at(6'd0);
    pedButton = 1'b0;
    chk("w.PED", 32'(PED), 32'd1);
    at(6'd0);
    chk("w.pending", 32'(PED), 32'd0);

    // async reset while in SG with PED set
    at(6'd3);
    pedButton = 1'b1;
    @(negedge clk);
    pedButton = 1'b0;
    at(6'd0);  chk("r.PED", 32'(PED), 32'd1);
    at(6'd20); lamps("r.SG", 3'b100, 3'b001, 1'b0);
    rst = 1'b1;
    #1;
    lamps("r.async", 3'b001, 3'b100, 1'b0);
    chk("r.counter", 32'(counter), 32'd0);
    chk("r.PEDclr", 32'(PED), 32'd0);

    // tick 1-of-4, enable held 4 clks at 11: single advance
    tdiv    = 1'b1;
    en_mode = 2;
    @(negedge clk);
    rst = 1'b0;
    at(6'd12); lamps("t.MY", 3'b010, 3'b100, 1'b0);
    at(6'd13); lamps("t.13", 3'b010, 3'b100, 1'b0);
    tdiv = 1'b0;

    // enable stuck after 11: watchdog behaviour at wrap
    at(6'd0);
`ifdef LIGHT_SEQ_WATCHDOG_EN
    lamps("wd.FLT", 3'b100, 3'b100, 1'b0);
    chk("wd.fault", 32'(fault), 32'd1);
`else
    lamps("wd.MY", 3'b010, 3'b100, 1'b0);
    chk("wd.fault", 32'(fault), 32'd0);
`endif
    @(negedge clk);
    chk("wd.counter", 32'(counter), 32'd1);
    en_mode = 1;
    at(6'd30);
`ifdef LIGHT_SEQ_WATCHDOG_EN
    lamps("wd.sticky", 3'b100, 3'b100, 1'b0);
    chk("wd.fault30", 32'(fault), 32'd1);
`else
    chk("wd.fault30", 32'(fault), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
